// File: rtl/spi_transaction_ctrl.sv
// spi_transaction_ctrl: sequences one SPI transaction in front of the SPI master core.
// It takes a chip-select/length command, drives the selected chip select with setup and
// hold delays, moves bytes one at a time between the requester and the core, and ends
// each command with a DONE pulse (ERR qualifies it).
// Optional build macro: SPI_TRANSACTION_TIMEOUT_EN adds a per-byte watchdog in WAIT_RX.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CMD_RDY high, waiting for a command
// CS_SETUP | chip select low, counting setup delay before the first byte
// WAIT_TX  | offering TX_RDY, waiting for the requester's next byte
// WAIT_RX  | byte handed to the core, waiting for its received byte
// CS_HOLD  | last byte done, counting hold delay before raising CS
// FINISH   | CS high, DONE/ERR issued on the next edge

module spi_transaction_ctrl #(
  parameter int NUM_CS       = 4,
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_HOLD_CYC  = 4,
  parameter int TIMEOUT_CYC  = 1024,
  localparam int CS_W        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VD,
  output logic              CMD_RDY,
  input  logic [CS_W-1:0]   CMD_CS,
  input  logic [7:0]        CMD_LEN,
  input  logic [7:0]        TX_DATA,
  input  logic              TX_VD,
  output logic              TX_RDY,
  output logic [7:0]        RX_DATA,
  output logic              RX_VD,
  output logic              DONE,
  output logic              ERR,
  input  logic              CORE_DATA_IN_RDY,
  output logic              CORE_DATA_IN_VD,
  output logic [7:0]        CORE_DATA_IN,
  input  logic [7:0]        CORE_DATA_OUT,
  input  logic              CORE_DATA_OUT_VD,
  output logic [NUM_CS-1:0] SPI_CS_N
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, WAIT_TX, WAIT_RX, CS_HOLD, FINISH} state_t;

  // One shared down-counter serves every delay, so it is sized for the longest one.
  localparam int TMR_MAX_SH = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int TMR_MAX    = (TMR_MAX_SH > TIMEOUT_CYC) ? TMR_MAX_SH : TIMEOUT_CYC;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(CS_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD_CYC - 1);
`ifdef SPI_TRANSACTION_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LD    = TMR_W'(TIMEOUT_CYC - 1);
`endif

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [7:0]          rem, rem_nxt;
  logic                err_flag, err_flag_nxt;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_nxt, cs_decode;
  logic                cmd_rdy_q, cmd_rdy_nxt;
  logic                tx_rdy_q, tx_rdy_nxt;
  logic                core_vd_q, core_vd_nxt;
  logic [7:0]          core_din_q, core_din_nxt;
  logic                rx_vd_q, rx_vd_nxt;
  logic [7:0]          rx_data_q, rx_data_nxt;
  logic                done_q, done_nxt;
  logic                err_q, err_nxt;
  logic                cs_oob;

  // An index at or above NUM_CS selects no line and ends the command with ERR.
  assign cs_oob = ({1'b0, CMD_CS} >= NUM_CS[CS_W:0]);

  // Active-low one-cold decode of the requested chip select.
  always_comb begin
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_decode[i] = (CMD_CS != CS_W'(i));
    end
  end

  // State and registered outputs; reset forces every chip select high immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      tmr        <= '0;
      rem        <= '0;
      err_flag   <= 1'b0;
      cs_n_q     <= '1;
      cmd_rdy_q  <= 1'b0;
      tx_rdy_q   <= 1'b0;
      core_vd_q  <= 1'b0;
      core_din_q <= '0;
      rx_vd_q    <= 1'b0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      rem        <= rem_nxt;
      err_flag   <= err_flag_nxt;
      cs_n_q     <= cs_n_nxt;
      cmd_rdy_q  <= cmd_rdy_nxt;
      tx_rdy_q   <= tx_rdy_nxt;
      core_vd_q  <= core_vd_nxt;
      core_din_q <= core_din_nxt;
      rx_vd_q    <= rx_vd_nxt;
      rx_data_q  <= rx_data_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    tmr_nxt      = (tmr != '0) ? tmr - TMR_W'(1) : tmr;
    rem_nxt      = rem;
    err_flag_nxt = err_flag;
    cs_n_nxt     = cs_n_q;
    cmd_rdy_nxt  = 1'b0;
    tx_rdy_nxt   = 1'b0;
    core_vd_nxt  = 1'b0;
    core_din_nxt = core_din_q;
    rx_vd_nxt    = 1'b0;
    rx_data_nxt  = rx_data_q;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy_nxt = 1'b1;
        if (CMD_VD && cmd_rdy_q) begin
          cmd_rdy_nxt  = 1'b0;
          rem_nxt      = CMD_LEN;
          err_flag_nxt = cs_oob;
          if ((CMD_LEN == 8'd0) || cs_oob) begin
            state_nxt = FINISH;
          end else begin
            cs_n_nxt  = cs_decode;
            tmr_nxt   = SETUP_LD;
            state_nxt = CS_SETUP;
          end
        end
      end
      CS_SETUP: begin
        if (tmr == '0) begin
          state_nxt  = WAIT_TX;
          tx_rdy_nxt = CORE_DATA_IN_RDY;
        end
      end
      WAIT_TX: begin
        if (TX_VD && tx_rdy_q) begin
          core_din_nxt = TX_DATA;
          core_vd_nxt  = 1'b1;
          state_nxt    = WAIT_RX;
`ifdef SPI_TRANSACTION_TIMEOUT_EN
          tmr_nxt      = TO_LD;
`endif
        end else begin
          tx_rdy_nxt = CORE_DATA_IN_RDY;
        end
      end
      WAIT_RX: begin
        if (CORE_DATA_OUT_VD) begin
          rx_data_nxt = CORE_DATA_OUT;
          rx_vd_nxt   = 1'b1;
          rem_nxt     = rem - 8'd1;
          if (rem == 8'd1) begin
            tmr_nxt   = HOLD_LD;
            state_nxt = CS_HOLD;
          end else begin
            tx_rdy_nxt = CORE_DATA_IN_RDY;
            state_nxt  = WAIT_TX;
          end
        end
`ifdef SPI_TRANSACTION_TIMEOUT_EN
        else if (tmr == '0) begin
          err_flag_nxt = 1'b1;
          tmr_nxt      = HOLD_LD;
          state_nxt    = CS_HOLD;
        end
`endif
      end
      CS_HOLD: begin
        if (tmr == '0) begin
          cs_n_nxt  = '1;
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        done_nxt  = 1'b1;
        err_nxt   = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign CMD_RDY         = cmd_rdy_q;
  assign TX_RDY          = tx_rdy_q;
  assign RX_DATA         = rx_data_q;
  assign RX_VD           = rx_vd_q;
  assign DONE            = done_q;
  assign ERR             = err_q;
  assign CORE_DATA_IN_VD = core_vd_q;
  assign CORE_DATA_IN    = core_din_q;
  assign SPI_CS_N        = cs_n_q;

endmodule
